// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, opcode/funct constants and ALU codes for the multicycle MIPS control
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps (aluOp, funct) to the 3-bit ALU control code
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unrecognised funct falls back to add; the writeback still happens.
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM; MIPS_BNE_EN adds bne support
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] aluControl,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic       pcEn,
  output logic       iOrD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;
  logic       pc_write, branch, take_branch;
  logic       src_a, ior_d, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg;
  logic [1:0] src_b, pc_src;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MIPS_BNE_EN
  logic bne_q, bne_d;

  always_ff @(posedge clk) begin
    if (reset) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_FETCH)       bne_d = 1'b0;
    else if (state_q == S_DECODE) bne_d = (op == OP_BNE);
  end

  assign take_branch = branch & (bne_q ? ~zero : zero);
`else
  assign take_branch = branch & zero;
`endif

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op     = ALUOP_ADD;
    src_a      = 1'b0;
    src_b      = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ior_d      = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr    = 1'b1;
        src_b    = 2'b01;
        pc_write = 1'b1;
      end
      S_DECODE:   src_b = 2'b11;
      S_MEMADR: begin
        src_a = 1'b1;
        src_b = 2'b10;
      end
      S_MEMRD:    ior_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
      end
      S_MEMWR: begin
        ior_d  = 1'b1;
        mem_wr = 1'b1;
      end
      S_EXECUTE: begin
        src_a  = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
      end
      S_BRANCH: begin
        src_a  = 1'b1;
        alu_op = ALUOP_SUB;
        pc_src = 2'b01;
        branch = 1'b1;
      end
      S_ADDIEXEC: begin
        src_a = 1'b1;
        src_b = 2'b10;
      end
      S_ADDIWB:   reg_wr = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (funct),
    .alu_control_o (alu_ctl)
  );

  // Reset masks every output so an aborted instruction cannot write anything.
  assign aluControl = reset ? ALU_ADD : alu_ctl;
  assign aluSrcA    = ~reset & src_a;
  assign aluSrcB    = reset ? 2'b00 : src_b;
  assign pcSrc      = reset ? 2'b00 : pc_src;
  assign pcEn       = ~reset & (pc_write | take_branch);
  assign iOrD       = ~reset & ior_d;
  assign memWrite   = ~reset & mem_wr;
  assign irWrite    = ~reset & ir_wr;
  assign regWrite   = ~reset & reg_wr;
  assign regDst     = ~reset & reg_dst;
  assign memToReg   = ~reset & mem_to_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed-vector bench for mips_multicycle_control
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic [2:0] aluControl;
  logic       aluSrcA, pcEn, iOrD, memWrite, irWrite, regWrite, regDst, memToReg;
  logic [1:0] aluSrcB, pcSrc;

  int n_checks = 0;
  int n_errors = 0;

  mips_multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .aluControl (aluControl),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .pcSrc      (pcSrc),
    .pcEn       (pcEn),
    .iOrD       (iOrD),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .memToReg   (memToReg)
  );

  always #5 clk = ~clk;

  // Order: aluControl, aluSrcA, aluSrcB, pcSrc, pcEn, iOrD, memWrite, irWrite, regWrite, regDst, memToReg
  logic [14:0] out_vec;
  assign out_vec = {aluControl, aluSrcA, aluSrcB, pcSrc, pcEn, iOrD,
                    memWrite, irWrite, regWrite, regDst, memToReg};

  function automatic logic [14:0] pk(input logic [2:0] c, input logic a, input logic [1:0] b,
                                     input logic [1:0] ps, input logic pe, input logic io,
                                     input logic mw, input logic iw, input logic rw,
                                     input logic rd, input logic mr);
    return {c, a, b, ps, pe, io, mw, iw, rw, rd, mr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [14:0] exp);
    @(negedge clk);
    check(tag, {17'd0, out_vec}, {17'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [14:0] v_rst, v_fetch, v_decode, v_memadr, v_memrd, v_memwb, v_memwr;
  logic [14:0] v_aluwb, v_addiexec, v_addiwb, v_jump, v_br_taken, v_br_not;

  logic [5:0] fn_tab [6];
  logic [2:0] ctl_tab [6];

  initial begin
    v_rst      = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    v_fetch    = pk(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0);
    v_decode   = pk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    v_memadr   = pk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    v_memrd    = pk(3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    v_memwb    = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1);
    v_memwr    = pk(3'b010, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0);
    v_aluwb    = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0);
    v_addiexec = pk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    v_addiwb   = pk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    v_jump     = pk(3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0);
    v_br_taken = pk(3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0);
    v_br_not   = pk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0);

    fn_tab[0] = 6'b100000; ctl_tab[0] = 3'b010;
    fn_tab[1] = 6'b100010; ctl_tab[1] = 3'b110;
    fn_tab[2] = 6'b100100; ctl_tab[2] = 3'b000;
    fn_tab[3] = 6'b100101; ctl_tab[3] = 3'b001;
    fn_tab[4] = 6'b101010; ctl_tab[4] = 3'b111;
    fn_tab[5] = 6'b111111; ctl_tab[5] = 3'b010;

    reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_0", v_rst);
    cyc("reset_1", v_rst);
    reset = 1'b0;

    // lw: 5 cycles; zero held high to show it cannot leak into pcEn
    op = 6'b100011; zero = 1'b1;
    cyc("lw_fetch", v_fetch);
    cyc("lw_decode", v_decode);
    cyc("lw_memadr", v_memadr);
    cyc("lw_memrd", v_memrd);
    cyc("lw_memwb", v_memwb);
    zero = 1'b0;

    op = 6'b101011;
    cyc("sw_fetch", v_fetch);
    cyc("sw_decode", v_decode);
    cyc("sw_memadr", v_memadr);
    cyc("sw_memwr", v_memwr);

    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      cyc($sformatf("r%0d_fetch", i), v_fetch);
      cyc($sformatf("r%0d_decode", i), v_decode);
      cyc($sformatf("r%0d_exec", i), pk(ctl_tab[i], 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      cyc($sformatf("r%0d_aluwb", i), v_aluwb);
    end

    op = 6'b001000;
    cyc("addi_fetch", v_fetch);
    cyc("addi_decode", v_decode);
    cyc("addi_exec", v_addiexec);
    cyc("addi_wb", v_addiwb);

    op = 6'b000010;
    cyc("j_fetch", v_fetch);
    cyc("j_decode", v_decode);
    cyc("j_jump", v_jump);

    op = 6'b000100; zero = 1'b1;
    cyc("beq1_fetch", v_fetch);
    cyc("beq1_decode", v_decode);
    cyc("beq1_branch", v_br_taken);
    zero = 1'b0;
    cyc("beq0_fetch", v_fetch);
    cyc("beq0_decode", v_decode);
    cyc("beq0_branch", v_br_not);

    op = 6'b111111;
    cyc("nop_fetch", v_fetch);
    cyc("nop_decode", v_decode);

    op = 6'b000101; zero = 1'b0;
    cyc("bne_fetch", v_fetch);
    cyc("bne_decode", v_decode);
`ifdef MIPS_BNE_EN
    cyc("bne0_branch", v_br_taken);
    zero = 1'b1;
    cyc("bne1_fetch", v_fetch);
    cyc("bne1_decode", v_decode);
    cyc("bne1_branch", v_br_not);
    // a following beq must not inherit the bne polarity
    op = 6'b000100;
    cyc("beq_after_bne_fetch", v_fetch);
    cyc("beq_after_bne_decode", v_decode);
    cyc("beq_after_bne_branch", v_br_taken);
    zero = 1'b0;
`endif

    // reset held 3 cycles starting in EXECUTE aborts the R-type before ALUWB
    op = 6'b000000; funct = 6'b100010;
    cyc("abort_fetch", v_fetch);
    cyc("abort_decode", v_decode);
    reset = 1'b1;
    cyc("abort_rst0", v_rst);
    cyc("abort_rst1", v_rst);
    cyc("abort_rst2", v_rst);
    reset = 1'b0;
    op = 6'b100011;
    cyc("post_rst_fetch", v_fetch);
    cyc("post_rst_decode", v_decode);
    cyc("post_rst_memadr", v_memadr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
